gps_ack_peak_collector: RTL and testbench
=========================================

Name: gps_ack_peak_collector

Overview:
Consumer of the gps_ack correlator result interface. It snoops every corr_complete event and keeps, per correlator channel, the best and second-best integrator values. For the best value it also keeps the sat ID, code phase and doppler. On search_complete it streams one result record per channel over a valid/ready port to the host/CPU side. Sits directly after gps_ack and replaces the file dump done in simulation.

Parameters:
NUM_CH, 8, number of parallel correlator channels (sat0..sat7).
SAT_W, 6, satellite ID width.
INTEG_W, 12, integrator width (unsigned).
PHASE_W, 10, code phase width.
DOPP_W, 16, doppler_omega width (signed).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
clear  in  1  pulse; start a new collection and wipe the tables
threshold  in  INTEG_W  detection threshold, sampled on entry to REPORT
corr_complete  in  1  level from gps_ack; the block acts on its rising edge
search_complete  in  1  level from gps_ack; the block acts on its rising edge
code_phase  in  PHASE_W  code phase of the current correlation
doppler_omega  in  DOPP_W  signed doppler of the current correlation
sat  in  NUM_CH*SAT_W  sat IDs, packed; channel k at [k*SAT_W +: SAT_W]
integrator  in  NUM_CH*INTEG_W  integrator values, packed the same way
out_valid  out  1  result record valid
out_ready  in  1  consumer accepts the record
out_ch  out  $clog2(NUM_CH)  channel index of the record
out_sat  out  SAT_W  sat ID captured with the best value
out_code_phase  out  PHASE_W  code phase of the best value
out_doppler  out  DOPP_W  doppler of the best value
out_peak  out  INTEG_W  best integrator value
out_second  out  INTEG_W  second-best integrator value
out_detected  out  1  out_peak >= sampled threshold
done  out  1  one-cycle pulse after the last record handshake
busy  out  1  high in COLLECT or REPORT
dropped  out  8  saturating count of corr_complete edges seen outside COLLECT

Behaviour:
- Reset state:
  - state=IDLE.
  - All table entries and all out_* = 0.
  - done=0, busy=0, dropped=0.
  - Edge-detect registers = 0.
- Edge detection: edge = signal & ~signal_q, with signal_q registered every cycle. A level held high produces one event only.
- States are IDLE, COLLECT and REPORT.
- clear has top priority in every state, including mid-REPORT:
  - Next state is COLLECT.
  - Tables are zeroed, out_valid=0, dropped=0.
  - No done pulse is generated.
- COLLECT, on a corr_complete edge, for each channel k in the same cycle, with v=integrator[k]:
  - If v > best_k: second_k<=best_k, best_k<=v, and sat_k/phase_k/dopp_k <= current inputs.
  - Else if v > second_k: second_k<=v.
  - Comparisons are strict, so on a tie the earliest value is kept.
  - Updated values are visible 1 cycle after the edge cycle.
- COLLECT, on a search_complete edge:
  - Next state is REPORT, threshold is latched, index=0.
  - If a corr_complete edge occurs in the same cycle, its table update is applied first.
- A corr_complete edge in IDLE or REPORT leaves the tables unchanged and increments dropped, saturating at 255.
- A search_complete edge outside COLLECT is ignored.
- REPORT:
  - out_valid=1 starting the cycle after entry, presenting the record for channel "index".
  - While out_valid && !out_ready, all out_* stay stable.
  - On a handshake, index increments and the next record appears in the following cycle. Back-to-back records are allowed with ready held high, giving 1 record/cycle.
  - After the handshake for index NUM_CH-1: out_valid=0, done=1 for one cycle, state=IDLE.
- out_detected = (best_k >= latched threshold), computed combinationally from the registered record.
- A channel never updated reports sat=0, peak=0, second=0, detected=(threshold==0).

Decomposition:
- Package gps_ack_pkg holds:
  - Width constants SAT_W, INTEG_W, PHASE_W, DOPP_W, NUM_CH (shared with gps_ack).
  - The state enum {IDLE, COLLECT, REPORT}.
  - A packed struct for the result record: sat, phase, doppler, peak, second.
- Sub-module gps_ack_peak_track holds one channel's best/second/sat/phase/doppler registers and the compare logic. It is instantiated NUM_CH times with a generate loop; the top level keeps the FSM, edge detectors, dropped counter and output mux.

Test Plan:
1. Reset, then clear; three corr_complete edges on ch0 with integrator 100, 250, 180 at phases 5, 17, 30; search_complete; ready held high -> ch0 record: peak=250, second=180, phase=17; all 8 records arrive on consecutive cycles; done pulses once.
2. Tie: ch3 gets 200 at phase 4, then 200 at phase 9 -> peak=200, phase=4, second=200.
3. corr_complete held high for 5 cycles in COLLECT -> exactly one update; 3 edges while in IDLE -> dropped=3; 300 edges -> dropped=255.
4. Backpressure: out_ready toggles 1-0-0-1 during REPORT -> record held stable while not ready; every channel is delivered exactly once, in order 0..7.
5. threshold=150 with peaks 149 and 150 on ch1/ch2 -> out_detected = 0 and 1 respectively; changing threshold mid-REPORT has no effect.
6. clear asserted during REPORT at index 3 -> out_valid drops the next cycle, no done pulse, tables read zero in the next report; rst mid-COLLECT -> all outputs return to reset values.

Source files
------------

// File: rtl/gps_ack_pkg.sv
// -----------------------------------------------------------------------------
// gps_ack_pkg
// Shared definitions for the gps_ack correlator and its peak collector:
//   - width constants for the correlator result interface
//   - FSM state encoding of the peak collector
//   - the per-channel result record streamed to the host side
// -----------------------------------------------------------------------------
package gps_ack_pkg;

    localparam int NUM_CH  = 8;   // parallel correlator channels
    localparam int SAT_W   = 6;   // satellite ID width
    localparam int INTEG_W = 12;  // unsigned integrator width
    localparam int PHASE_W = 10;  // code phase width
    localparam int DOPP_W  = 16;  // signed doppler_omega width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_e;

    // One channel's result as presented on the output port.
    typedef struct packed {
        logic [SAT_W-1:0]          sat;
        logic [PHASE_W-1:0]        phase;
        logic signed [DOPP_W-1:0]  doppler;
        logic [INTEG_W-1:0]        peak;
        logic [INTEG_W-1:0]        second;
    } result_rec_t;

endpackage

// File: rtl/gps_ack_peak_track.sv
// -----------------------------------------------------------------------------
// gps_ack_peak_track
// Tracks the best and second-best integrator value of one correlator channel,
// together with the sat ID, code phase and doppler seen with the best value.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr_i      wipe the table entry (wins over upd_i)
//   upd_i      one correlation result is available this cycle
//   integ_i    integrator value of this channel
//   sat_i      sat ID of this channel
//   phase_i    code phase of the current correlation
//   dopp_i     doppler of the current correlation
//   best_o     best value so far
//   second_o   second-best value so far
//   sat_o, phase_o, dopp_o   context captured with best_o
// -----------------------------------------------------------------------------
module gps_ack_peak_track
    import gps_ack_pkg::*;
#(
    parameter int SAT_W   = gps_ack_pkg::SAT_W,
    parameter int INTEG_W = gps_ack_pkg::INTEG_W,
    parameter int PHASE_W = gps_ack_pkg::PHASE_W,
    parameter int DOPP_W  = gps_ack_pkg::DOPP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      upd_i,
    input  logic [INTEG_W-1:0]        integ_i,
    input  logic [SAT_W-1:0]          sat_i,
    input  logic [PHASE_W-1:0]        phase_i,
    input  logic signed [DOPP_W-1:0]  dopp_i,
    output logic [INTEG_W-1:0]        best_o,
    output logic [INTEG_W-1:0]        second_o,
    output logic [SAT_W-1:0]          sat_o,
    output logic [PHASE_W-1:0]        phase_o,
    output logic signed [DOPP_W-1:0]  dopp_o
);

    logic [INTEG_W-1:0]        best_q,   best_d;
    logic [INTEG_W-1:0]        second_q, second_d;
    logic [SAT_W-1:0]          sat_q,    sat_d;
    logic [PHASE_W-1:0]        phase_q,  phase_d;
    logic signed [DOPP_W-1:0]  dopp_q,   dopp_d;

    // Strict comparisons: on a tie the earlier value keeps the best slot and
    // the newcomer can still fill the second slot.
    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        sat_d    = sat_q;
        phase_d  = phase_q;
        dopp_d   = dopp_q;
        if (clr_i) begin
            best_d   = '0;
            second_d = '0;
            sat_d    = '0;
            phase_d  = '0;
            dopp_d   = '0;
        end else if (upd_i) begin
            if (integ_i > best_q) begin
                second_d = best_q;
                best_d   = integ_i;
                sat_d    = sat_i;
                phase_d  = phase_i;
                dopp_d   = dopp_i;
            end else if (integ_i > second_q) begin
                second_d = integ_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q   <= '0;
            second_q <= '0;
            sat_q    <= '0;
            phase_q  <= '0;
            dopp_q   <= '0;
        end else begin
            best_q   <= best_d;
            second_q <= second_d;
            sat_q    <= sat_d;
            phase_q  <= phase_d;
            dopp_q   <= dopp_d;
        end
    end

    assign best_o   = best_q;
    assign second_o = second_q;
    assign sat_o    = sat_q;
    assign phase_o  = phase_q;
    assign dopp_o   = dopp_q;

endmodule

// File: rtl/gps_ack_peak_collector.sv
// -----------------------------------------------------------------------------
// gps_ack_peak_collector
// Snoops the gps_ack correlator result interface. During a collection it keeps
// per channel the best and second-best integrator value (plus sat ID, code
// phase and doppler of the best). When the search completes it streams one
// record per channel, in channel order, over a valid/ready port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             start a new collection, wipe tables (top priority)
//   threshold         detection threshold, latched when the report starts
//   corr_complete     correlation done (level, rising edge acts)
//   search_complete   search done (level, rising edge acts)
//   code_phase        code phase of the current correlation
//   doppler_omega     signed doppler of the current correlation
//   sat, integrator   per-channel packed sat IDs / integrator values
//   out_valid/out_ready   record handshake
//   out_ch, out_sat, out_code_phase, out_doppler, out_peak, out_second
//                     record contents
//   out_detected      peak >= latched threshold (only while out_valid)
//   done              one-cycle pulse after the last record handshake
//   busy              collecting or reporting
//   dropped           saturating count of corr_complete edges outside COLLECT
// -----------------------------------------------------------------------------
module gps_ack_peak_collector
    import gps_ack_pkg::*;
#(
    parameter int NUM_CH  = gps_ack_pkg::NUM_CH,
    parameter int SAT_W   = gps_ack_pkg::SAT_W,
    parameter int INTEG_W = gps_ack_pkg::INTEG_W,
    parameter int PHASE_W = gps_ack_pkg::PHASE_W,
    parameter int DOPP_W  = gps_ack_pkg::DOPP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [INTEG_W-1:0]           threshold,
    input  logic                         corr_complete,
    input  logic                         search_complete,
    input  logic [PHASE_W-1:0]           code_phase,
    input  logic signed [DOPP_W-1:0]     doppler_omega,
    input  logic [NUM_CH*SAT_W-1:0]      sat,
    input  logic [NUM_CH*INTEG_W-1:0]    integrator,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic [SAT_W-1:0]             out_sat,
    output logic [PHASE_W-1:0]           out_code_phase,
    output logic signed [DOPP_W-1:0]     out_doppler,
    output logic [INTEG_W-1:0]           out_peak,
    output logic [INTEG_W-1:0]           out_second,
    output logic                         out_detected,
    output logic                         done,
    output logic                         busy,
    output logic [7:0]                   dropped
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic                corr_q, search_q;
    logic                corr_edge, search_edge;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt, load_idx;
    logic [INTEG_W-1:0]  thr_q, thr_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic [7:0]          dropped_q, dropped_d;
    logic [IDX_W-1:0]    ch_q, ch_d;
    result_rec_t         rec_q, rec_d, sel_rec;
    logic                tbl_clr, tbl_upd;

    logic [INTEG_W-1:0]        best_w   [NUM_CH];
    logic [INTEG_W-1:0]        second_w [NUM_CH];
    logic [SAT_W-1:0]          sat_w    [NUM_CH];
    logic [PHASE_W-1:0]        phase_w  [NUM_CH];
    logic signed [DOPP_W-1:0]  dopp_w   [NUM_CH];

    assign corr_edge   = corr_complete & ~corr_q;
    assign search_edge = search_complete & ~search_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        gps_ack_peak_track #(
            .SAT_W   (SAT_W),
            .INTEG_W (INTEG_W),
            .PHASE_W (PHASE_W),
            .DOPP_W  (DOPP_W)
        ) u_track (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (tbl_clr),
            .upd_i    (tbl_upd),
            .integ_i  (integrator[k*INTEG_W +: INTEG_W]),
            .sat_i    (sat[k*SAT_W +: SAT_W]),
            .phase_i  (code_phase),
            .dopp_i   (doppler_omega),
            .best_o   (best_w[k]),
            .second_o (second_w[k]),
            .sat_o    (sat_w[k]),
            .phase_o  (phase_w[k]),
            .dopp_o   (dopp_w[k])
        );
    end

    // Record source: the first record of a report is channel idx_q; once a
    // record is on the port, the one to load next is idx_q + 1.
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        load_idx       = out_valid_q ? idx_nxt : idx_q;
        sel_rec        = '0;
        sel_rec.sat    = sat_w[load_idx];
        sel_rec.phase  = phase_w[load_idx];
        sel_rec.doppler = dopp_w[load_idx];
        sel_rec.peak   = best_w[load_idx];
        sel_rec.second = second_w[load_idx];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        thr_d       = thr_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;
        ch_d        = ch_q;
        rec_d       = rec_q;
        tbl_clr     = 1'b0;
        tbl_upd     = 1'b0;

        if (clear) begin
            state_d     = COLLECT;
            tbl_clr     = 1'b1;
            idx_d       = '0;
            out_valid_d = 1'b0;
            dropped_d   = '0;
            ch_d        = '0;
            rec_d       = '0;
        end else begin
            if (corr_edge && (state_q != COLLECT) && (dropped_q != 8'hFF)) begin
                dropped_d = dropped_q + 8'd1;
            end
            unique case (state_q)
                COLLECT: begin
                    // A simultaneous corr_complete edge still lands in the
                    // tables; they become visible as the report starts.
                    tbl_upd = corr_edge;
                    if (search_edge) begin
                        state_d = REPORT;
                        thr_d   = threshold;
                        idx_d   = '0;
                    end
                end
                REPORT: begin
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        ch_d        = idx_q;
                        rec_d       = sel_rec;
                    end else if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            idx_d = idx_nxt;
                            ch_d  = idx_nxt;
                            rec_d = sel_rec;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            corr_q      <= 1'b0;
            search_q    <= 1'b0;
            idx_q       <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= '0;
            ch_q        <= '0;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            corr_q      <= corr_complete;
            search_q    <= search_complete;
            idx_q       <= idx_d;
            thr_q       <= thr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
            ch_q        <= ch_d;
            rec_q       <= rec_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_ch         = ch_q;
    assign out_sat        = rec_q.sat;
    assign out_code_phase = rec_q.phase;
    assign out_doppler    = rec_q.doppler;
    assign out_peak       = rec_q.peak;
    assign out_second     = rec_q.second;
    // Qualified by out_valid so an idle port (peak 0, threshold 0) reads 0.
    assign out_detected   = out_valid_q && (rec_q.peak >= thr_q);
    assign done           = done_q;
    assign busy           = (state_q != IDLE);
    assign dropped        = dropped_q;

endmodule

// File: tb/tb_gps_ack_peak_collector.sv
// -----------------------------------------------------------------------------
// tb_gps_ack_peak_collector
// Directed sequence with randomized data. The reference keeps every accepted
// correlation per channel and derives each record by sorting those values.
// -----------------------------------------------------------------------------
module tb_gps_ack_peak_collector;

    localparam int NCH = 8;
    localparam int SW  = 6;
    localparam int IW  = 12;
    localparam int PW  = 10;
    localparam int DW  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear;
    logic [IW-1:0]          threshold;
    logic                   corr_complete;
    logic                   search_complete;
    logic [PW-1:0]          code_phase;
    logic signed [DW-1:0]   doppler_omega;
    logic [NCH*SW-1:0]      sat;
    logic [NCH*IW-1:0]      integrator;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_ch;
    logic [SW-1:0]          out_sat;
    logic [PW-1:0]          out_code_phase;
    logic signed [DW-1:0]   out_doppler;
    logic [IW-1:0]          out_peak;
    logic [IW-1:0]          out_second;
    logic                   out_detected;
    logic                   done;
    logic                   busy;
    logic [7:0]             dropped;

    always #5 clk = ~clk;

    gps_ack_peak_collector dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .threshold       (threshold),
        .corr_complete   (corr_complete),
        .search_complete (search_complete),
        .code_phase      (code_phase),
        .doppler_omega   (doppler_omega),
        .sat             (sat),
        .integrator      (integrator),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_sat         (out_sat),
        .out_code_phase  (out_code_phase),
        .out_doppler     (out_doppler),
        .out_peak        (out_peak),
        .out_second      (out_second),
        .out_detected    (out_detected),
        .done            (done),
        .busy            (busy),
        .dropped         (dropped)
    );

    typedef struct {
        int ch;
        int v;
        int s;
        int ph;
        int dp;
    } ent_t;

    ent_t ents[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_collect = 1'b0;
    int   m_dropped = 0;
    int   m_thr = 0;
    int   got_pk  [NCH];
    int   got_sc  [NCH];
    int   got_ph  [NCH];
    int   got_det [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*IW-1:0] rand_iv(input int lim);
        logic [NCH*IW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*IW +: IW] = IW'($urandom_range(lim, 0));
        return r;
    endfunction

    // Best = largest value seen (context from its earliest occurrence),
    // second = next element of the descending-sorted value list.
    task automatic model_rec(input int k, output int e_sat, output int e_ph,
                             output int e_dp, output int e_pk, output int e_sc);
        int  vals[$];
        bit  found;
        e_sat = 0; e_ph = 0; e_dp = 0; e_pk = 0; e_sc = 0;
        found = 1'b0;
        foreach (ents[i]) if (ents[i].ch == k) vals.push_back(ents[i].v);
        vals.rsort();
        if (vals.size() > 0) e_pk = vals[0];
        if (vals.size() > 1) e_sc = vals[1];
        if (e_pk > 0) begin
            foreach (ents[i]) begin
                if (!found && ents[i].ch == k && ents[i].v == e_pk) begin
                    found = 1'b1;
                    e_sat = ents[i].s;
                    e_ph  = ents[i].ph;
                    e_dp  = ents[i].dp;
                end
            end
        end
    endtask

    task automatic corr_event(input logic [NCH*IW-1:0] iv, input int ph, input int hold);
        logic [NCH*SW-1:0] sv;
        int dp;
        for (int k = 0; k < NCH; k++) sv[k*SW +: SW] = SW'($urandom_range(63, 0));
        dp = int'($urandom_range(65535, 0)) - 32768;
        integrator    = iv;
        sat           = sv;
        code_phase    = PW'(ph);
        doppler_omega = DW'(dp);
        corr_complete = 1'b1;
        repeat (hold) tick();
        corr_complete = 1'b0;
        tick();
        if (m_collect) begin
            for (int k = 0; k < NCH; k++)
                ents.push_back('{ch: k, v: int'(iv[k*IW +: IW]), s: int'(sv[k*SW +: SW]),
                                 ph: ph, dp: dp});
        end else if (m_dropped < 255) begin
            m_dropped++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ents.delete();
        m_collect = 1'b1;
        m_dropped = 0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1-0-0-1 on valid cycles.
    // abort_at >= 0 asserts clear while that record is on the port.
    // new_thr >= 0 changes the threshold input after the first handshake.
    task automatic run_report(input int mode, input int abort_at, input int new_thr);
        int  idx = 0, vcnt = 0, first_v = -1, last_hs = -1, dcnt = 0;
        int  e_sat, e_ph, e_dp, e_pk, e_sc;
        bit  held = 1'b0;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] cur, saved, exp;
        m_thr = int'(threshold);
        search_complete = 1'b1;
        tick();
        search_complete = 1'b0;
        m_collect = 1'b0;
        saved = '0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done === 1'b1) dcnt++;
            if (out_valid === 1'b1) begin
                cur = 64'({out_ch, out_sat, out_code_phase, out_doppler,
                           out_peak, out_second, out_detected});
                if (held) chk("hold_stable", cur, saved);
                if (first_v < 0) first_v = cyc;
                if (idx == abort_at) begin
                    out_ready = 1'b0;
                    clear = 1'b1;
                    tick();
                    clear = 1'b0;
                    ents.delete();
                    m_collect = 1'b1;
                    m_dropped = 0;
                    chk("abort_valid", 64'(out_valid), 64'(0));
                    chk("abort_busy", 64'(busy), 64'(1));
                    repeat (4) begin
                        if (done === 1'b1) dcnt++;
                        tick();
                    end
                    chk("abort_no_done", 64'(dcnt), 64'(0));
                    return;
                end
                out_ready = (mode == 0) ? 1'b1 : pat[vcnt % 4];
                vcnt++;
                if (out_ready) begin
                    model_rec(idx, e_sat, e_ph, e_dp, e_pk, e_sc);
                    exp = 64'({3'(idx), SW'(e_sat), PW'(e_ph), DW'(e_dp),
                               IW'(e_pk), IW'(e_sc), (e_pk >= m_thr)});
                    chk("record", cur, exp);
                    got_pk[idx]  = int'(out_peak);
                    got_sc[idx]  = int'(out_second);
                    got_ph[idx]  = int'(out_code_phase);
                    got_det[idx] = int'(out_detected);
                    idx++;
                    last_hs = cyc;
                    held = 1'b0;
                    if (idx == 1 && new_thr >= 0) threshold = IW'(new_thr);
                end else begin
                    saved = cur;
                    held = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(1, 0));
            end
            if (idx == NCH && cyc > last_hs + 4) break;
            tick();
        end
        out_ready = 1'b0;
        chk("delivered", 64'(idx), 64'(NCH));
        chk("done_pulses", 64'(dcnt), 64'(1));
        if (mode == 0) chk("back_to_back", 64'(last_hs - first_v), 64'(NCH - 1));
        chk("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [NCH*IW-1:0] iv;

        rst = 1'b1;
        clear = 1'b0;
        threshold = '0;
        corr_complete = 1'b0;
        search_complete = 1'b0;
        code_phase = '0;
        doppler_omega = '0;
        sat = '0;
        integrator = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            64'({out_valid, out_ch, out_sat, out_code_phase, out_doppler, out_peak,
                 out_second, out_detected, done, busy, dropped}), 64'(0));
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));

        // corr_complete edges while idle are only counted
        repeat (3) corr_event(rand_iv(4095), int'($urandom_range(1023, 0)), 1);
        chk("dropped_idle", 64'(dropped), 64'(m_dropped));
        chk("dropped_is_3", 64'(dropped), 64'(3));

        // search_complete outside COLLECT does nothing
        search_complete = 1'b1;
        tick();
        search_complete = 1'b0;
        repeat (3) tick();
        chk("search_idle_busy", 64'(busy), 64'(0));
        chk("search_idle_valid", 64'(out_valid), 64'(0));

        // ch0 sequence 100/250/180, ready held high
        do_clear();
        chk("clear_busy", 64'(busy), 64'(1));
        chk("clear_dropped", 64'(dropped), 64'(0));
        iv = rand_iv(4095); iv[0 +: IW] = 12'd100; corr_event(iv, 5, 1);
        iv = rand_iv(4095); iv[0 +: IW] = 12'd250; corr_event(iv, 17, 1);
        iv = rand_iv(4095); iv[0 +: IW] = 12'd180; corr_event(iv, 30, 1);
        threshold = IW'($urandom_range(4095, 0));
        run_report(0, -1, -1);
        chk("ch0_peak", 64'(got_pk[0]), 64'(250));
        chk("ch0_second", 64'(got_sc[0]), 64'(180));
        chk("ch0_phase", 64'(got_ph[0]), 64'(17));

        // tie on ch3, a held corr_complete, then backpressure
        do_clear();
        iv = rand_iv(3000); iv[3*IW +: IW] = 12'd200; corr_event(iv, 4, 1);
        iv = rand_iv(3000); iv[3*IW +: IW] = 12'd200; corr_event(iv, 9, 1);
        // ch5 gets a unique maximum on a 5-cycle level: a repeated update
        // would also pull second up to 4000
        iv = rand_iv(3000); iv[3*IW +: IW] = 12'd100; iv[5*IW +: IW] = 12'd4000;
        corr_event(iv, int'($urandom_range(1023, 0)), 5);
        repeat (3) begin
            iv = rand_iv(3000);
            iv[3*IW +: IW] = IW'($urandom_range(199, 0));
            corr_event(iv, int'($urandom_range(1023, 0)), 1);
        end
        chk("collect_dropped", 64'(dropped), 64'(0));
        threshold = IW'($urandom_range(3000, 0));
        run_report(1, -1, -1);
        chk("tie_peak", 64'(got_pk[3]), 64'(200));
        chk("tie_phase", 64'(got_ph[3]), 64'(4));
        chk("tie_second", 64'(got_sc[3]), 64'(200));
        chk("hold_peak", 64'(got_pk[5]), 64'(4000));

        // threshold boundary, threshold change mid-report ignored
        do_clear();
        iv = rand_iv(4095); iv[1*IW +: IW] = 12'd149; iv[2*IW +: IW] = 12'd150;
        corr_event(iv, int'($urandom_range(1023, 0)), 1);
        threshold = 12'd150;
        run_report(0, -1, 4095);
        chk("det_149", 64'(got_det[1]), 64'(0));
        chk("det_150", 64'(got_det[2]), 64'(1));

        // clear in the middle of a report, then an empty report
        do_clear();
        repeat (3) corr_event(rand_iv(4095), int'($urandom_range(1023, 0)), 1);
        threshold = IW'($urandom_range(4095, 0));
        run_report(0, 3, -1);
        threshold = '0;
        run_report(0, -1, -1);
        chk("empty_peak", 64'(got_pk[5]), 64'(0));
        chk("empty_det", 64'(got_det[5]), 64'(1));

        // dropped counter saturates
        repeat (300) corr_event(rand_iv(4095), int'($urandom_range(1023, 0)), 1);
        chk("dropped_sat", 64'(dropped), 64'(m_dropped));
        chk("dropped_255", 64'(dropped), 64'(255));

        // reset in the middle of a collection
        do_clear();
        repeat (2) corr_event(rand_iv(4095), int'($urandom_range(1023, 0)), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ents.delete();
        m_collect = 1'b0;
        m_dropped = 0;
        chk("rst_mid_collect",
            64'({out_valid, out_ch, out_sat, out_code_phase, out_doppler, out_peak,
                 out_second, out_detected, done, busy, dropped}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
